// File: rtl/lcd_panel_rx.sv
// Panel-side receiver for the 8080-style 8-bit LCD write bus: decodes window setup
// and memory-write commands into addressed RGB565 pixel strobes, and generates fmark.
module lcd_panel_rx #(
  parameter int unsigned CW           = 9,
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 240,
  parameter logic [15:0] FMARK_PERIOD = 16'd2000,
  parameter int unsigned FMARK_WIDTH  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    lcd_d,
  input  logic          lcd_rs,
  input  logic          lcd_wr_n,
  output logic          lcd_fmark,
  output logic          ev_valid,
  output logic          ev_rs,
  output logic [7:0]    ev_data,
  output logic          px_valid,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic [15:0]   px_data,
  output logic [CW-1:0] win_sc,
  output logic [CW-1:0] win_ec,
  output logic [CW-1:0] win_sp,
  output logic [CW-1:0] win_ep
);

  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, OTHER} state_t;

  state_t        state, state_nx;
  logic [7:0]    d_s1, d_s2;
  logic          rs_s1, rs_s2, wr_s1, wr_s2, wr_prev;
  logic          wr_rise;
  logic [2:0]    idx;
  logic [7:0]    hi_byte;
  logic [CW-1:0] start_val, x, y;
  logic [15:0]   fm_cnt;

  // wr_n synchronizer and its history reset high so reset release is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_s1    <= '0;
      d_s2    <= '0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      d_s1    <= lcd_d;
      d_s2    <= d_s1;
      rs_s1   <= lcd_rs;
      rs_s2   <= rs_s1;
      wr_s1   <= lcd_wr_n;
      wr_s2   <= wr_s1;
      wr_prev <= wr_s2;
    end
  end

  assign wr_rise = wr_s2 & ~wr_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (wr_rise && !rs_s2) begin
      case (d_s2)
        8'h2A:        state_nx = CASET;
        8'h2B:        state_nx = PASET;
        8'h2C, 8'h3C: state_nx = RAMWR;
        default:      state_nx = OTHER;
      endcase
    end
  end

  // hi_byte doubles as the pixel-pair latch and the pending high byte of a coordinate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid  <= 1'b0;
      ev_rs     <= 1'b0;
      ev_data   <= '0;
      px_valid  <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      px_data   <= '0;
      win_sc    <= '0;
      win_ec    <= CW'(WIDTH - 1);
      win_sp    <= '0;
      win_ep    <= CW'(HEIGHT - 1);
      idx       <= '0;
      hi_byte   <= '0;
      start_val <= '0;
      x         <= '0;
      y         <= '0;
    end else begin
      ev_valid <= wr_rise;
      px_valid <= 1'b0;
      if (wr_rise) begin
        ev_rs   <= rs_s2;
        ev_data <= d_s2;
        if (!rs_s2) begin
          idx     <= '0;
          hi_byte <= '0;
          if (d_s2 == 8'h2C) begin
            x <= win_sc;
            y <= win_sp;
          end
        end else begin
          case (state)
            CASET, PASET: begin
              if (idx != 3'd4) begin
                idx <= idx + 3'd1;
                case (idx[1:0])
                  2'd0, 2'd2: hi_byte <= d_s2;
                  2'd1:       start_val <= CW'({hi_byte, d_s2});
                  2'd3: begin
                    if (state == CASET) begin
                      win_sc <= start_val;
                      win_ec <= CW'({hi_byte, d_s2});
                    end else begin
                      win_sp <= start_val;
                      win_ep <= CW'({hi_byte, d_s2});
                    end
                  end
                endcase
              end
            end
            RAMWR: begin
              idx <= {2'b00, ~idx[0]};
              if (!idx[0]) begin
                hi_byte <= d_s2;
              end else begin
                px_valid <= 1'b1;
                px_x     <= x;
                px_y     <= y;
                px_data  <= {hi_byte, d_s2};
                if (x == win_ec) begin
                  x <= win_sc;
                  y <= (y == win_ep) ? win_sp : y + CW'(1);
                end else begin
                  x <= x + CW'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fm_cnt    <= '0;
      lcd_fmark <= 1'b0;
    end else if (FMARK_PERIOD == 16'd0) begin
      fm_cnt    <= '0;
      lcd_fmark <= 1'b0;
    end else begin
      lcd_fmark <= (fm_cnt < 16'(FMARK_WIDTH));
      fm_cnt    <= (fm_cnt == FMARK_PERIOD - 16'd1) ? '0 : fm_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_lcd_panel_rx.sv
// Self-checking bench for lcd_panel_rx: directed scenarios plus random byte streams
// compared against a behavioural model of the command/window/pixel rules.
module tb_lcd_panel_rx;
  localparam int CW = 9;
  localparam int M  = 1 << CW;

  logic          clk = 1'b0, rst = 1'b0;
  logic [7:0]    lcd_d = '0;
  logic          lcd_rs = 1'b0, lcd_wr_n = 1'b1;
  logic          lcd_fmark, ev_valid, ev_rs, px_valid;
  logic [7:0]    ev_data;
  logic [CW-1:0] px_x, px_y, win_sc, win_ec, win_sp, win_ep;
  logic [15:0]   px_data;

  lcd_panel_rx #(.CW(CW), .WIDTH(320), .HEIGHT(240), .FMARK_PERIOD(16'd2000), .FMARK_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .lcd_d(lcd_d), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
    .lcd_fmark(lcd_fmark), .ev_valid(ev_valid), .ev_rs(ev_rs), .ev_data(ev_data),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .win_sc(win_sc), .win_ec(win_ec), .win_sp(win_sp), .win_ep(win_ep)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  // observations from the last bus write
  logic          o_ev, o_ev2, o_rs, o_px;
  int            o_lat;
  logic [7:0]    o_d;
  logic [CW-1:0] o_x, o_y;
  logic [15:0]   o_pd;

  // reference model state
  int m_sc, m_ec, m_sp, m_ep, m_mode, m_n, m_x, m_y, m_hi;
  int m_b[4];
  logic          e_px;
  logic [CW-1:0] e_x, e_y;
  logic [15:0]   e_d;

  function automatic void model_reset();
    m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239;
    m_mode = 0; m_n = 0; m_x = 0; m_y = 0; m_hi = 0;
  endfunction

  // mode: 0 idle/other, 1 column setup, 2 page setup, 3 memory write
  function automatic void model_byte(input logic rs, input logic [7:0] d);
    e_px = 1'b0;
    if (!rs) begin
      m_n = 0;
      case (d)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; end
        8'h3C: m_mode = 3;
        default: m_mode = 0;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_n < 4) begin
        m_b[m_n] = int'(d);
        m_n++;
        if (m_n == 4) begin
          if (m_mode == 1) begin
            m_sc = (m_b[0] * 256 + m_b[1]) % M;
            m_ec = (m_b[2] * 256 + m_b[3]) % M;
          end else begin
            m_sp = (m_b[0] * 256 + m_b[1]) % M;
            m_ep = (m_b[2] * 256 + m_b[3]) % M;
          end
        end
      end
    end else if (m_mode == 3) begin
      if (m_n % 2 == 0) m_hi = int'(d);
      else begin
        e_px = 1'b1;
        e_x  = CW'(m_x);
        e_y  = CW'(m_y);
        e_d  = 16'(m_hi * 256 + int'(d));
        if (m_x == m_ec) begin
          m_x = m_sc;
          m_y = (m_y == m_ep) ? m_sp : (m_y + 1) % M;
        end else m_x = (m_x + 1) % M;
      end
      m_n++;
    end
  endfunction

  task automatic xfer(input logic rs, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_d = d; lcd_rs = rs; lcd_wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 lcd_wr_n = 1'b1;
    o_ev = 1'b0; o_lat = 0; o_px = 1'b0; o_rs = 1'b0; o_d = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ev_valid) begin
        o_ev = 1'b1; o_lat = i; o_rs = ev_rs; o_d = ev_data;
        o_px = px_valid; o_x = px_x; o_y = px_y; o_pd = px_data;
        break;
      end
    end
    @(posedge clk); #1 o_ev2 = ev_valid | px_valid;
  endtask

  task automatic test_reset();
    logic [9:0] fm;
    int rise_t;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ev_valid, ev_rs, ev_data, px_valid, px_x, px_y, px_data, lcd_fmark} !== '0)
      $display("FAIL reset_outputs: got ev=%b rs=%b d=%h px=%b x=%0d y=%0d pd=%h fm=%b, want all 0",
               ev_valid, ev_rs, ev_data, px_valid, px_x, px_y, px_data, lcd_fmark);
    else n_pass++;
    n_checks++;
    if (win_sc !== 9'd0 || win_ec !== 9'd319 || win_sp !== 9'd0 || win_ep !== 9'd239)
      $display("FAIL reset_window: got %0d %0d %0d %0d, want 0 319 0 239", win_sc, win_ec, win_sp, win_ep);
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    model_reset();
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk); #1 fm[t-1] = lcd_fmark;
    end
    n_checks++;
    if (fm !== 10'b00_1111_1111) $display("FAIL fmark_pulse: got %b, want 0011111111", fm);
    else n_pass++;
    rise_t = 0;
    for (int t = 11; t <= 2100; t++) begin
      @(posedge clk); #1;
      if (lcd_fmark) begin rise_t = t; break; end
    end
    n_checks++;
    if (rise_t != 2001) $display("FAIL fmark_period: next rise at cycle %0d, want 2001", rise_t);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [8:0] seq [2] = '{9'h001, 9'h1A5};
    foreach (seq[i]) begin
      xfer(seq[i][8], seq[i][7:0]); model_byte(seq[i][8], seq[i][7:0]);
      n_checks++;
      if (o_ev !== 1'b1 || o_lat < 3 || o_lat > 4 || o_ev2 !== 1'b0 || {o_rs, o_d} !== seq[i])
        $display("FAIL basic_ev[%0d]: got ev=%b lat=%0d after=%b rs/d=%h, want ev=1 lat=3..4 after=0 rs/d=%h",
                 i, o_ev, o_lat, o_ev2, {o_rs, o_d}, seq[i]);
      else n_pass++;
      n_checks++;
      if (o_px !== 1'b0) $display("FAIL basic_px[%0d]: got px_valid=%b, want 0", i, o_px);
      else n_pass++;
    end
    n_checks++;
    if (win_sc !== 9'd0 || win_ec !== 9'd319 || win_sp !== 9'd0 || win_ep !== 9'd239)
      $display("FAIL basic_window: got %0d %0d %0d %0d, want 0 319 0 239", win_sc, win_ec, win_sp, win_ep);
    else n_pass++;
  endtask

  task automatic test_window_wrap();
    logic [8:0] seq [25] = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10C,
                             9'h02B, 9'h100, 9'h105, 9'h100, 9'h106, 9'h02C,
                             9'h112, 9'h134, 9'h101, 9'h102, 9'h103, 9'h104, 9'h105,
                             9'h106, 9'h107, 9'h108, 9'h109, 9'h10A, 9'h10B, 9'h10C};
    logic [8:0] seq2 [7] = '{9'h02A, 9'h100, 9'h120, 9'h02B, 9'h03C, 9'h156, 9'h178};
    logic [17:0] want [7] = '{{9'd10, 9'd5}, {9'd11, 9'd5}, {9'd12, 9'd5}, {9'd10, 9'd6},
                              {9'd11, 9'd6}, {9'd12, 9'd6}, {9'd10, 9'd5}};
    logic [17:0] got [$];
    logic ok;
    foreach (seq[i]) begin
      xfer(seq[i][8], seq[i][7:0]); model_byte(seq[i][8], seq[i][7:0]);
      n_checks++;
      if (o_ev !== 1'b1 || o_lat < 3 || o_lat > 4 || o_ev2 !== 1'b0 || {o_rs, o_d} !== seq[i])
        $display("FAIL wrap_ev[%0d]: got ev=%b lat=%0d after=%b rs/d=%h, want ev=1 lat=3..4 after=0 rs/d=%h",
                 i, o_ev, o_lat, o_ev2, {o_rs, o_d}, seq[i]);
      else n_pass++;
      n_checks++;
      if (o_px !== e_px || (e_px && {o_x, o_y, o_pd} !== {e_x, e_y, e_d}))
        $display("FAIL wrap_px[%0d]: got v=%b (%0d,%0d) %h, want v=%b (%0d,%0d) %h",
                 i, o_px, o_x, o_y, o_pd, e_px, e_x, e_y, e_d);
      else n_pass++;
      if (o_px === 1'b1) got.push_back({o_x, o_y});
      if (i == 12 && o_pd !== 16'h1234) begin
        n_checks++;
        $display("FAIL wrap_first_data: got %h, want 1234", o_pd);
      end
    end
    ok = (got.size() == 7);
    if (ok) foreach (want[i]) if (got[i] !== want[i]) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL wrap_coords: got %0d pixels, first=%h, want 7 pixels from (10,5)",
                      got.size(), (got.size() > 0) ? got[0] : 18'h0);
    else n_pass++;
    foreach (seq2[i]) begin
      xfer(seq2[i][8], seq2[i][7:0]); model_byte(seq2[i][8], seq2[i][7:0]);
      n_checks++;
      if (o_px !== e_px || (e_px && {o_x, o_y, o_pd} !== {e_x, e_y, e_d}) || {o_rs, o_d} !== seq2[i])
        $display("FAIL partial_cont[%0d]: got v=%b (%0d,%0d) %h ev=%h, want v=%b (%0d,%0d) %h ev=%h",
                 i, o_px, o_x, o_y, o_pd, {o_rs, o_d}, e_px, e_x, e_y, e_d, seq2[i]);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (win_sc !== 9'd10 || win_ec !== 9'd12)
          $display("FAIL partial_caset: got sc=%0d ec=%0d, want 10 12", win_sc, win_ec);
        else n_pass++;
      end
    end
    n_checks++;
    if ({o_x, o_y, o_pd} !== {9'd11, 9'd5, 16'h5678})
      $display("FAIL ramwr_cont: got (%0d,%0d) %h, want (11,5) 5678", o_x, o_y, o_pd);
    else n_pass++;
  endtask

  task automatic test_odd_drop();
    logic [8:0] seq [7] = '{9'h02C, 9'h1AA, 9'h1BB, 9'h1CC, 9'h02C, 9'h111, 9'h122};
    foreach (seq[i]) begin
      xfer(seq[i][8], seq[i][7:0]); model_byte(seq[i][8], seq[i][7:0]);
      n_checks++;
      if (o_ev !== 1'b1 || {o_rs, o_d} !== seq[i] || o_px !== e_px ||
          (e_px && {o_x, o_y, o_pd} !== {e_x, e_y, e_d}))
        $display("FAIL odd_drop[%0d]: got ev=%b rs/d=%h v=%b (%0d,%0d) %h, want ev=1 rs/d=%h v=%b (%0d,%0d) %h",
                 i, o_ev, {o_rs, o_d}, o_px, o_x, o_y, o_pd, seq[i], e_px, e_x, e_y, e_d);
      else n_pass++;
    end
    n_checks++;
    if ({o_x, o_y, o_pd} !== {9'd10, 9'd5, 16'h1122})
      $display("FAIL odd_drop_last: got (%0d,%0d) %h, want (10,5) 1122", o_x, o_y, o_pd);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [8:0] seq [2] = '{9'h1DE, 9'h1AD};
    xfer(1'b0, 8'h2C); model_byte(1'b0, 8'h2C);
    xfer(1'b1, 8'h55); model_byte(1'b1, 8'h55);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    model_reset();
    foreach (seq[i]) begin
      xfer(seq[i][8], seq[i][7:0]); model_byte(seq[i][8], seq[i][7:0]);
      n_checks++;
      if (o_ev !== 1'b1 || {o_rs, o_d} !== seq[i] || o_px !== 1'b0 || e_px !== 1'b0)
        $display("FAIL reset_mid[%0d]: got ev=%b rs/d=%h px=%b, want ev=1 rs/d=%h px=0",
                 i, o_ev, {o_rs, o_d}, o_px, seq[i]);
      else n_pass++;
    end
    n_checks++;
    if (win_sc !== 9'd0 || win_ec !== 9'd319 || win_sp !== 9'd0 || win_ep !== 9'd239)
      $display("FAIL reset_mid_window: got %0d %0d %0d %0d, want 0 319 0 239", win_sc, win_ec, win_sp, win_ep);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] cmds [4] = '{8'h2A, 8'h2B, 8'h2C, 8'h3C};
    for (int i = 0; i < 200; i++) begin
      logic rs;
      logic [7:0] d;
      int pick;
      rs = ($urandom_range(0, 3) != 0);
      pick = int'($urandom_range(0, 4));
      if (rs || pick == 4) d = 8'($urandom_range(0, 255));
      else d = cmds[pick];
      xfer(rs, d); model_byte(rs, d);
      n_checks++;
      if (o_ev !== 1'b1 || o_lat < 3 || o_lat > 4 || o_ev2 !== 1'b0 || {o_rs, o_d} !== {rs, d} ||
          o_px !== e_px || (e_px && {o_x, o_y, o_pd} !== {e_x, e_y, e_d}))
        $display("FAIL random[%0d]: got ev=%b lat=%0d rs/d=%h v=%b (%0d,%0d) %h, want ev=1 rs/d=%h v=%b (%0d,%0d) %h",
                 i, o_ev, o_lat, {o_rs, o_d}, o_px, o_x, o_y, o_pd, {rs, d}, e_px, e_x, e_y, e_d);
      else n_pass++;
      n_checks++;
      if (win_sc !== CW'(m_sc) || win_ec !== CW'(m_ec) || win_sp !== CW'(m_sp) || win_ep !== CW'(m_ep))
        $display("FAIL random_window[%0d]: got %0d %0d %0d %0d, want %0d %0d %0d %0d",
                 i, win_sc, win_ec, win_sp, win_ep, m_sc, m_ec, m_sp, m_ep);
      else n_pass++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_window_wrap();
    test_odd_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
